// File: rtl/fifo_read_drainer_if.sv
// rtl/fifo_read_drainer_if.sv - FIFO read port plus valid/ready output stream of the drainer.
interface fifo_read_drainer_if #(
  parameter int FIFO_WIDTH = 16
);
  logic                  fifo_rd_en;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output fifo_rd_en, m_data, m_valid,
    input  fifo_data_out, fifo_empty, fifo_underflow, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_data, m_valid,
    output fifo_data_out, fifo_empty, fifo_underflow, m_ready
  );
endinterface

// File: rtl/fifo_read_drainer.sv
// rtl/fifo_read_drainer.sv - credit-based FIFO drainer with elastic buffer, read counter and underflow flag.
module fifo_read_drainer #(
  parameter int FIFO_WIDTH = 16,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  fifo_read_drainer_if.master  bus,
  output logic [15:0]          rd_count,
  output logic                 underflow_err
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic {ST_HOLD, ST_RUN} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  run;
  logic [OCC_W-1:0]      occ;
  logic                  in_flight;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [FIFO_WIDTH-1:0] mem [BUF_DEPTH];
  logic [OCC_W:0]        credit_used;
  logic                  rd_en;
  logic                  capture;
  logic                  pop;
  logic                  valid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HOLD;
    else        state <= state_nxt;
  end

  // Reads count the word already in flight against the buffer, so a capture always has room.
  always_comb begin
    state_nxt   = state;
    run         = 1'b0;
    if (state == ST_HOLD) state_nxt = ST_RUN;
    else                  run       = 1'b1;
    credit_used = {1'b0, occ} + (OCC_W+1)'(in_flight);
    valid       = (occ != '0);
    rd_en       = run & ~flush & ~bus.fifo_empty & (credit_used < (OCC_W+1)'(BUF_DEPTH));
    capture     = in_flight & ~flush;
    pop         = valid & bus.m_ready;
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_data     = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (capture) begin
      mem[wr_ptr] <= bus.fifo_data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ           <= '0;
      in_flight     <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rd_count      <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (flush) begin
        occ       <= '0;
        in_flight <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
      end else begin
        in_flight <= rd_en;
        if (capture) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)     rd_ptr <= ptr_inc(rd_ptr);
        case ({capture, pop})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
      end
      if (rd_en) rd_count <= rd_count + 16'd1;
      if (run && bus.fifo_underflow) underflow_err <= 1'b1;
    end
  end

  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    credit_used <= (OCC_W+1)'(BUF_DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    capture |-> (occ != OCC_W'(BUF_DEPTH)));
endmodule

// File: doc/fifo_read_drainer.md
# fifo_read_drainer

Synthesizable read-side consumer that sits directly downstream of the FIFO, on the same read port the FIFO monitor observes. It drains the FIFO whenever it has buffer room and presents the words on a valid/ready stream through a small elastic buffer. It compensates for the FIFO's one-cycle read latency and keeps full throughput. It also counts issued reads and flags FIFO read-protocol errors (underflow).

## Interface
- FIFO_WIDTH, 16: data word width.
- BUF_DEPTH, 4: elastic buffer entries. Legal values are 3..16; 3 is the minimum for 1 word/cycle.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset. The clock is `clk` and the reset is `rst_n`; reset is asynchronous and active-low.
- flush  in  1  synchronous clear of buffered and in-flight data.
- fifo_data_out  in  FIFO_WIDTH  FIFO read data, valid the cycle after a granted read.
- fifo_empty  in  1  FIFO empty flag.
- fifo_underflow  in  1  FIFO underflow flag.
- fifo_rd_en  out  1  read request to the FIFO.
- m_data  out  FIFO_WIDTH  head of the elastic buffer.
- m_valid  out  1  m_data holds a word.
- m_ready  in  1  downstream accept.
- rd_count  out  16  reads issued, modulo 2^16.
- underflow_err  out  1  sticky protocol-error flag.

## Operation
- State:
  - occ: buffer occupancy, 0..BUF_DEPTH.
  - in_flight: 1 when a read was issued last cycle.
  - run: 0 in reset, 1 from the first posedge after rst_n rises.
  - Circular buffer with wr_ptr/rd_ptr of width $clog2(BUF_DEPTH), wrapping BUF_DEPTH-1 -> 0.
- Read request (combinational from registered state plus inputs): fifo_rd_en = run & !flush & !fifo_empty & ((occ + in_flight) < BUF_DEPTH).
- in_flight <= fifo_rd_en & !flush.
- Capture: at a posedge with in_flight=1 and flush=0, write fifo_data_out at wr_ptr and increment wr_ptr.
- Output:
  - m_valid = (occ != 0).
  - m_data = buf[rd_ptr].
  - A pop occurs when m_valid & m_ready; rd_ptr increments.
- occ update: +1 on capture only, -1 on pop only, unchanged when both or neither happen.
- Credit rule: occ + in_flight never exceeds BUF_DEPTH, so a capture never finds the buffer full. Reaching that condition is a design bug; an assertion checks it.
- flush:
  - Next posedge: occ=0, ptrs=0, in_flight=0.
  - Data returning from a read issued the cycle before flush is discarded.
  - fifo_rd_en=0 during the flush cycle.
  - rd_count and underflow_err are unaffected.
- rd_count increments on every posedge where fifo_rd_en=1, wrapping 0xFFFF -> 0x0000.
- underflow_err is set when fifo_underflow=1 at a posedge with run=1, and cleared only by reset. The block never reads an empty FIFO, so a set flag indicates a FIFO or shared-port fault.

## Timing
- Reset values (asynchronous on rst_n=0): fifo_rd_en=0, m_valid=0, m_data=0 (buffer cleared), rd_count=0, underflow_err=0, occ=0, in_flight=0, run=0.
- fifo_rd_en stays 0 for the whole reset period and for the first posedge after release.
- Latency:
  - Read granted at posedge N.
  - FIFO word captured at posedge N+1.
  - m_valid=1 after posedge N+1 (2 cycles from fifo_rd_en to m_valid).
- Throughput: 1 word/cycle sustained with m_ready=1 and FIFO non-empty, for BUF_DEPTH>=3.
- Backpressure: with m_ready=0, reads stop once occ + in_flight = BUF_DEPTH. With BUF_DEPTH=4, this is exactly 4 buffered words and no loss.
- Simultaneous capture and pop at occ=BUF_DEPTH-1 or occ=1 leaves occ unchanged. Order is preserved: the popped word is the old head.
- fifo_empty rising while in_flight=1: the in-flight word is still captured, and no new read is issued.
- Reset mid-transfer discards all data. The first read after release follows the run rule above.

## Test plan
- Reset release with FIFO holding 0x0001..0x0005 and m_ready=1:
  - fifo_rd_en low during reset and on the first posedge after release.
  - Words 0x0001..0x0005 appear on consecutive cycles.
  - rd_count=5 and no gaps.
- m_ready=0 with 10 words in FIFO:
  - Exactly 4 reads issued; rd_count=4; m_valid=1 with m_data=first word.
  - fifo_rd_en then stays 0.
  - Releasing m_ready yields all 10 words in order.
- Random m_ready (50%) over 1000 words:
  - Output sequence equals input sequence.
  - occ + in_flight never exceeds 4.
- flush asserted the cycle after a read with 2 words buffered:
  - Next cycle m_valid=0.
  - The in-flight word is dropped, and the next output is the following FIFO word.
- FIFO empties mid-stream (3 words, then empty for 5 cycles, then 2 words):
  - No fifo_rd_en while empty.
  - 5 words out in order.
  - underflow_err=0.
- Force fifo_underflow=1 for one cycle: underflow_err=1 and it stays set until rst_n=0.
- Wrap check: 65537 reads give rd_count=0x0001.
